// File: rtl/xcheck_scheduler.sv
// Round-robin scheduler that shares one external X/Z checker between NUM_CH
// monitored lanes, tracking consecutive unknown results and sticky faults.

module xcheck_lane #(
  parameter int THRESH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic upd,
  input  logic unknown,
  input  logic clr,
  output logic fault
);
  localparam int RUN_W = $clog2(THRESH + 1);

  logic [RUN_W-1:0] run, run_inc;
  logic             hit;

  assign run_inc = (run == RUN_W'(THRESH)) ? run : run + 1'b1;
  assign hit     = upd && unknown && (run_inc == RUN_W'(THRESH));

  // A fault being set beats a clear arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      run   <= '0;
      fault <= 1'b0;
    end else if (hit) begin
      run   <= RUN_W'(THRESH);
      fault <= 1'b1;
    end else if (clr) begin
      run   <= '0;
      fault <= 1'b0;
    end else if (upd) begin
      run <= unknown ? run_inc : '0;
    end
  end
endmodule

module xcheck_scheduler #(
  parameter int NUM_CH  = 4,
  parameter int THRESH  = 2,
  parameter int TIMEOUT = 8,
  parameter int CNT_W   = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [NUM_CH-1:0]         ch_mask,
  output logic                      chk_req,
  output logic [$clog2(NUM_CH)-1:0] chk_ch,
  input  logic                      chk_ack,
  input  logic                      chk_unknown,
  input  logic [NUM_CH-1:0]         fault_clr,
  output logic [NUM_CH-1:0]         fault,
  output logic [CNT_W-1:0]          viol_cnt,
  output logic                      scan_done,
  output logic                      busy
);
  localparam int CH_W = $clog2(NUM_CH);
  localparam int TW   = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, SELECT, WAIT, UPDATE} state_t;

  typedef struct packed {
    logic            vld;
    logic [CH_W-1:0] ch;
  } chk_req_t;

  state_t            state, state_nx;
  chk_req_t          req_q;
  logic [CH_W-1:0]   rr, rr_nx, sel_ch;
  logic              sel_found, last, res_unk, timeout_hit, upd_st;
  logic [CH_W:0]     sum;
  logic [NUM_CH-1:0] mask_q;
  logic [TW-1:0]     tcnt;

  assign chk_req     = req_q.vld;
  assign chk_ch      = req_q.ch;
  assign busy        = (state != IDLE);
  assign upd_st      = (state == UPDATE);
  assign timeout_hit = (tcnt == TW'(TIMEOUT - 1));
  assign rr_nx       = (req_q.ch == CH_W'(NUM_CH - 1)) ? '0 : req_q.ch + 1'b1;

  // First enabled channel at or after the rr pointer, wrapping at NUM_CH.
  always_comb begin
    sel_ch    = '0;
    sel_found = 1'b0;
    sum       = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      sum = {1'b0, rr} + (CH_W+1)'(k);
      if (sum >= (CH_W+1)'(NUM_CH)) sum = sum - (CH_W+1)'(NUM_CH);
      if (!sel_found && ch_mask[sum[CH_W-1:0]]) begin
        sel_found = 1'b1;
        sel_ch    = sum[CH_W-1:0];
      end
    end
  end

  // A round ends when no channel above the current one was enabled at select.
  always_comb begin
    last = 1'b1;
    for (int j = 0; j < NUM_CH; j++)
      if (j > int'(req_q.ch) && mask_q[j]) last = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (en && (ch_mask != '0)) state_nx = SELECT;
      SELECT:  state_nx = sel_found ? WAIT : IDLE;
      WAIT:    if (chk_ack || timeout_hit) state_nx = UPDATE;
      UPDATE:  state_nx = en ? SELECT : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      req_q     <= '0;
      rr        <= '0;
      mask_q    <= '0;
      tcnt      <= '0;
      res_unk   <= 1'b0;
      viol_cnt  <= '0;
      scan_done <= 1'b0;
    end else begin
      scan_done <= 1'b0;
      case (state)
        SELECT: if (sel_found) begin
          req_q  <= '{vld: 1'b1, ch: sel_ch};
          mask_q <= ch_mask;
          tcnt   <= '0;
        end
        WAIT: begin
          tcnt <= tcnt + 1'b1;
          if (chk_ack) begin
            res_unk   <= chk_unknown;
            req_q.vld <= 1'b0;
          end else if (timeout_hit) begin
            res_unk   <= 1'b1;
            req_q.vld <= 1'b0;
          end
        end
        UPDATE: begin
          rr        <= rr_nx;
          scan_done <= last;
          if (res_unk && (viol_cnt != '1)) viol_cnt <= viol_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    xcheck_lane #(.THRESH(THRESH)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .upd     (upd_st && (req_q.ch == CH_W'(i))),
      .unknown (res_unk),
      .clr     (fault_clr[i]),
      .fault   (fault[i])
    );
  end
endmodule

// File: tb/tb_xcheck_scheduler.sv
// Bench for xcheck_scheduler: a transaction-timeline model predicts every
// output each cycle; directed scenarios pin the model with literal values.

module tb_xcheck_scheduler;
  localparam int NUM_CH  = 4;
  localparam int THRESH  = 2;
  localparam int TIMEOUT = 8;
  localparam int CNT_W   = 8;
  localparam int CH_W    = $clog2(NUM_CH);
  localparam int VMAX    = (1 << CNT_W) - 1;

  logic              clk = 0, rst = 0, en = 0, chk_ack = 0, chk_unknown = 0;
  logic [NUM_CH-1:0] ch_mask = '0, fault_clr = '0, fault;
  logic              chk_req, scan_done, busy;
  logic [CH_W-1:0]   chk_ch;
  logic [CNT_W-1:0]  viol_cnt;

  xcheck_scheduler #(.NUM_CH(NUM_CH), .THRESH(THRESH), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .en(en), .ch_mask(ch_mask), .chk_req(chk_req), .chk_ch(chk_ch),
    .chk_ack(chk_ack), .chk_unknown(chk_unknown), .fault_clr(fault_clr), .fault(fault),
    .viol_cnt(viol_cnt), .scan_done(scan_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0, cyc = 0;

  // model state
  int                m_run[NUM_CH];
  logic [NUM_CH-1:0] m_fault = '0;
  int                m_viol = 0, m_rr = 0;
  bit                act = 0, pend = 0, exp_scan = 0, rst_prev = 0;
  int                S, E, sel_c, cur_ch, cur_lat, vis_c, p_ch, set_ch;
  bit                cur_to, cur_unk, p_unk, p_scan;
  logic [NUM_CH-1:0] sel_mask, clr_prev = '0;

  // knobs
  bit                k_en = 0, k_rand = 0, k_drop = 0;
  int                k_txleft = 0, k_fixlat = 1, k_rst = 0;
  logic [NUM_CH-1:0] k_unk_ch = '0, k_to_ch = '0, k_clr_at_e = '0, k_clr_once = '0;

  // observation logs
  int   log_ch[$], rise[$];
  int   scan_cnt = 0, req_hi = 0;
  logic req_prev = 0;
  int   exp_rr[6] = '{0, 1, 3, 0, 1, 3};

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, got, exp, cyc);
  endtask

  function automatic logic [NUM_CH-1:0] rand_nz();
    logic [NUM_CH-1:0] v;
    do v = NUM_CH'($urandom); while (v == '0);
    return v;
  endfunction

  function automatic int next_ch(input int from, input logic [NUM_CH-1:0] m);
    for (int k = 0; k < NUM_CH; k++)
      if (m[CH_W'((from + k) % NUM_CH)]) return (from + k) % NUM_CH;
    return 0;
  endfunction

  // Schedule a check whose request is expected to be visible from cycle s.
  task automatic begin_tx(input int s);
    int r;
    S = s; sel_c = s - 1; act = 1;
    cur_ch = next_ch(m_rr, ch_mask);
    sel_mask = ch_mask;
    if (k_txleft > 0) k_txleft--;
    cur_to = 0; cur_lat = k_fixlat;
    if (k_to_ch[cur_ch]) cur_to = 1;
    else if (k_rand) begin
      r = $urandom_range(0, 9);
      cur_to  = (r == 0);
      cur_lat = (r == 1) ? TIMEOUT - 1 : $urandom_range(0, 3);
    end
    if (cur_to) cur_lat = TIMEOUT;
    E = S + (cur_to ? TIMEOUT : cur_lat + 1);
    cur_unk = k_rand ? ($urandom_range(0, 2) == 0) : k_unk_ch[cur_ch];
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    exp_scan = 0;
    set_ch = -1;
    if (!rst_prev) begin
      m_fault = '0; m_viol = 0; m_rr = 0; act = 0; pend = 0;
      for (int i = 0; i < NUM_CH; i++) m_run[i] = 0;
    end else begin
      if (pend && cyc == vis_c) begin
        pend = 0;
        exp_scan = p_scan;
        if (p_unk) begin
          if (m_viol < VMAX) m_viol++;
          if (m_run[p_ch] < THRESH) m_run[p_ch]++;
          if (m_run[p_ch] == THRESH) begin m_fault[p_ch] = 1'b1; set_ch = p_ch; end
        end else m_run[p_ch] = 0;
      end
      for (int i = 0; i < NUM_CH; i++)
        if (clr_prev[i] && i != set_ch) begin m_run[i] = 0; m_fault[i] = 1'b0; end
    end

    chk("chk_req", 32'(chk_req), 32'(act && cyc >= S && cyc < E));
    if (act && cyc >= S && cyc < E) chk("chk_ch", 32'(chk_ch), 32'(cur_ch));
    chk("busy", 32'(busy), 32'(act && cyc >= sel_c && cyc <= E));
    chk("fault", 32'(fault), 32'(m_fault));
    chk("viol_cnt", 32'(viol_cnt), 32'(m_viol));
    chk("scan_done", 32'(scan_done), 32'(exp_scan));

    if (chk_req && !req_prev) begin log_ch.push_back(int'(chk_ch)); rise.push_back(cyc); end
    req_prev = chk_req;
    if (chk_req) req_hi++;
    if (scan_done) scan_cnt++;

    chk_ack = 0; chk_unknown = 1'($urandom_range(0, 1)); fault_clr = '0; rst = 1;
    if (k_rand && $urandom_range(0, 9) == 0) fault_clr = NUM_CH'($urandom);
    if (k_clr_once != '0) begin fault_clr = k_clr_once; k_clr_once = '0; end
    if (k_rst > 0 || (k_rand && $urandom_range(0, 199) == 0)) begin
      rst = 0; act = 0; pend = 0;
      if (k_rst > 0) k_rst--;
    end
    if (rst) begin
      if (act && !cur_to && cyc == S + cur_lat) begin
        chk_ack = 1; chk_unknown = cur_unk;
      end else if (k_rand && !(act && cyc >= S && cyc < E) && $urandom_range(0, 3) == 0)
        chk_ack = 1;
      if (act && cyc == E) begin
        fault_clr = fault_clr | k_clr_at_e;
        pend = 1; vis_c = cyc + 1; p_ch = cur_ch; p_unk = cur_to || cur_unk;
        p_scan = ((sel_mask >> (cur_ch + 1)) == '0);
        m_rr = (cur_ch + 1) % NUM_CH;
        en = k_en && k_txleft != 0 && (!k_rand || $urandom_range(0, 6) != 0);
        if (en) begin_tx(cyc + 2); else act = 0;
      end else if (act) begin
        if (cyc == S && k_rand && $urandom_range(0, 3) == 0) ch_mask = rand_nz();
        if (k_drop && cyc >= S) k_en = 0;
        en = k_rand ? 1'($urandom_range(0, 1)) : k_en;
      end else begin
        if (k_rand && $urandom_range(0, 3) == 0)
          ch_mask = ($urandom_range(0, 7) == 0) ? '0 : rand_nz();
        en = k_en && k_txleft != 0 && (!k_rand || $urandom_range(0, 3) != 0);
        if (en && ch_mask != '0) begin_tx(cyc + 2);
      end
    end
    clr_prev = fault_clr;
    rst_prev = rst;
  endtask

  task automatic run_tx(input int n);
    int budget = 0;
    k_en = 1; k_txleft = n;
    do begin step(); budget++; end
    while (((k_txleft != 0 && k_en) || act || pend) && budget < 20000);
    if (budget >= 20000) begin
      n_chk++;
      $display("FAIL run_tx: cycle budget expired with %0d checks left", k_txleft);
    end
    k_en = 0; k_txleft = 0;
    step(); step();
  endtask

  task automatic do_reset();
    k_rst = 2;
    step(); step(); step();
    log_ch.delete(); rise.delete(); scan_cnt = 0; req_hi = 0;
  endtask

  initial begin
    // reset and idle
    do_reset();
    chk("rst_req", 32'(chk_req), 0);
    chk("rst_ch", 32'(chk_ch), 0);
    chk("rst_fault", 32'(fault), 0);
    chk("rst_viol", 32'(viol_cnt), 0);
    chk("rst_busy", 32'(busy), 0);
    k_en = 1; k_txleft = 1; ch_mask = '0;
    repeat (6) step();
    chk("mask0_busy", 32'(busy), 0);
    chk("mask0_reqs", 32'(req_hi), 0);
    k_en = 0; k_txleft = 0;

    // round robin over 1011
    do_reset();
    ch_mask = 4'b1011; k_fixlat = 1;
    run_tx(6);
    chk("rr_len", 32'(log_ch.size()), 6);
    for (int i = 0; i < 6 && i < log_ch.size(); i++) chk("rr_seq", 32'(log_ch[i]), 32'(exp_rr[i]));
    chk("rr_scan", 32'(scan_cnt), 2);
    if (rise.size() > 1) chk("rr_period", 32'(rise[1] - rise[0]), 4);
    chk("rr_fault", 32'(fault), 0);
    chk("rr_viol", 32'(viol_cnt), 0);

    // threshold on ch 2
    do_reset();
    ch_mask = 4'b1111; k_unk_ch = 4'b0100;
    run_tx(8);
    chk("thr_fault", 32'(fault), 32'h4);
    chk("thr_viol", 32'(viol_cnt), 2);
    k_unk_ch = '0;
    run_tx(4);
    chk("thr_sticky", 32'(fault), 32'h4);

    // run counter reset by a known result
    do_reset();
    ch_mask = 4'b0010;
    k_unk_ch = 4'b0010; run_tx(1);
    k_unk_ch = '0;      run_tx(1);
    k_unk_ch = 4'b0010; run_tx(1);
    chk("run_fault", 32'(fault), 0);
    chk("run_viol", 32'(viol_cnt), 2);

    // timeouts on ch 0
    do_reset();
    ch_mask = 4'b0001; k_unk_ch = '0; k_to_ch = 4'b0001;
    run_tx(1);
    chk("to_reqlen", 32'(req_hi), 32'(TIMEOUT));
    chk("to_viol1", 32'(viol_cnt), 1);
    chk("to_fault1", 32'(fault), 0);
    run_tx(1);
    chk("to_fault2", 32'(fault), 32'h1);
    chk("to_viol2", 32'(viol_cnt), 2);
    k_to_ch = '0;

    // clear collides with set, then a later clear
    do_reset();
    ch_mask = 4'b0100; k_unk_ch = 4'b0100;
    run_tx(1);
    k_clr_at_e = 4'b0100;
    run_tx(1);
    chk("clr_collide", 32'(fault), 32'h4);
    k_clr_at_e = '0; k_clr_once = 4'b0100;
    step(); step();
    chk("clr_later", 32'(fault), 0);
    run_tx(1);
    chk("clr_run", 32'(fault), 0);
    chk("clr_viol", 32'(viol_cnt), 3);

    // en dropped while waiting for the ack
    do_reset();
    ch_mask = 4'b0001; k_unk_ch = '0; k_fixlat = 3; k_drop = 1;
    run_tx(5);
    k_drop = 0;
    chk("drop_busy", 32'(busy), 0);
    chk("drop_req", 32'(chk_req), 0);
    chk("drop_count", 32'(log_ch.size()), 1);

    // violation counter saturation
    do_reset();
    ch_mask = 4'b1111; k_unk_ch = 4'b1111; k_fixlat = 0;
    run_tx(VMAX + 5);
    chk("sat_viol", 32'(viol_cnt), 32'(VMAX));
    chk("sat_fault", 32'(fault), 32'hF);
    k_unk_ch = '0; k_fixlat = 1;

    // randomized traffic, masks, clears, acks and resets
    do_reset();
    k_rand = 1; ch_mask = rand_nz();
    run_tx(400);
    k_rand = 0;
    step(); step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
